// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer.
// Holds the control state encoding and the per-frame output count.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        WAIT,
        OUT
    } state_t;

    function automatic int y_count(input int x_size, input int f_size);
        return x_size - f_size + 1;
    endfunction

endpackage

// File: rtl/load_counter.sv
// Fill counter for one input stream: ready, write enable and write address.
// Saturates at SIZE; clear_i empties it for the next frame.
module load_counter #(
    parameter int SIZE = 8,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_i,
    input  logic          clear_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] addr_o,
    output logic          full_o
);

    localparam int CW = $clog2(SIZE + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CW'(SIZE));
    assign ready_o = enable_i & ~full_o;
    assign wr_en_o = valid_i & ready_o;
    assign addr_o  = cnt_q[AW-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wr_en_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for the convolution datapath: loads x/f memories, sequences
// reads and accumulator control per output, and hands y to the consumer.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int X_SIZE = 8,
    parameter int F_SIZE = 4,
    parameter int X_AW   = $clog2(X_SIZE),
    parameter int F_AW   = $clog2(F_SIZE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid_x,
    output logic            s_ready_x,
    input  logic            s_valid_f,
    output logic            s_ready_f,
    output logic [X_AW-1:0] x_addr,
    output logic            x_wr_en,
    output logic [F_AW-1:0] f_addr,
    output logic            f_wr_en,
    output logic            acc_en,
    output logic            acc_first,
    output logic            m_valid_y,
    input  logic            m_ready_y,
    output logic            frame_done
);

    localparam int Y_COUNT = y_count(X_SIZE, F_SIZE);
    localparam logic [F_AW-1:0] K_LAST = F_AW'(F_SIZE - 1);
    localparam logic [X_AW-1:0] B_LAST = X_AW'(Y_COUNT - 1);

    state_t          state_q;
    logic [X_AW-1:0] base_q;
    logic [F_AW-1:0] k_q;
    logic            acc_en_q, acc_first_q, m_valid_q;

    logic            in_load, x_full, f_full, frame_last;
    logic [X_AW-1:0] x_ld_addr;
    logic [F_AW-1:0] f_ld_addr;

    assign in_load    = (state_q == LOAD);
    assign frame_last = (state_q == OUT) && m_ready_y && (base_q == B_LAST);

    load_counter #(.SIZE(X_SIZE), .AW(X_AW)) u_x_cnt (
        .clk      (clk),
        .reset    (reset),
        .enable_i (in_load),
        .clear_i  (frame_last),
        .valid_i  (s_valid_x),
        .ready_o  (s_ready_x),
        .wr_en_o  (x_wr_en),
        .addr_o   (x_ld_addr),
        .full_o   (x_full)
    );

    load_counter #(.SIZE(F_SIZE), .AW(F_AW)) u_f_cnt (
        .clk      (clk),
        .reset    (reset),
        .enable_i (in_load),
        .clear_i  (frame_last),
        .valid_i  (s_valid_f),
        .ready_o  (s_ready_f),
        .wr_en_o  (f_wr_en),
        .addr_o   (f_ld_addr),
        .full_o   (f_full)
    );

    // Outside LOAD the read address parks on the last tap, so it holds during a stall.
    assign x_addr     = in_load ? x_ld_addr : base_q + X_AW'(k_q);
    assign f_addr     = in_load ? f_ld_addr : k_q;
    assign acc_en     = acc_en_q;
    assign acc_first  = acc_first_q;
    assign m_valid_y  = m_valid_q;
    assign frame_done = frame_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            base_q      <= '0;
            k_q         <= '0;
            acc_en_q    <= 1'b0;
            acc_first_q <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            // Read issued this cycle returns next cycle, so accumulate lags by one.
            acc_en_q    <= (state_q == COMPUTE);
            acc_first_q <= (state_q == COMPUTE) && (k_q == '0);
            unique case (state_q)
                LOAD: begin
                    if (x_full && f_full) begin
                        state_q <= COMPUTE;
                        base_q  <= '0;
                        k_q     <= '0;
                    end
                end
                COMPUTE: begin
                    if (k_q == K_LAST) begin
                        state_q <= WAIT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                WAIT: begin
                    state_q   <= OUT;
                    m_valid_q <= 1'b1;
                end
                OUT: begin
                    if (m_ready_y) begin
                        m_valid_q <= 1'b0;
                        k_q       <= '0;
                        if (base_q == B_LAST) begin
                            state_q <= LOAD;
                            base_q  <= '0;
                        end else begin
                            state_q <= COMPUTE;
                            base_q  <= base_q + 1'b1;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with a reference memory/MAC datapath.
module tb_conv_sequencer;

    localparam int XS   = 8;
    localparam int FS   = 4;
    localparam int YC   = XS - FS + 1;
    localparam int X_AW = $clog2(XS);
    localparam int F_AW = $clog2(FS);

    logic            clk = 1'b0;
    logic            reset;
    logic            s_valid_x, s_ready_x, s_valid_f, s_ready_f;
    logic [X_AW-1:0] x_addr;
    logic [F_AW-1:0] f_addr;
    logic            x_wr_en, f_wr_en, acc_en, acc_first;
    logic            m_valid_y, m_ready_y, frame_done;

    logic signed [7:0]  xmem [XS];
    logic signed [7:0]  fmem [FS];
    logic signed [7:0]  x_rd, f_rd, x_data, f_data;
    logic signed [31:0] acc, prod;

    int xv [XS];
    int fv [FS];
    int expy [YC];
    int cyc = 0;
    int last_acc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_sequencer #(.X_SIZE(XS), .F_SIZE(FS)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_x  (s_valid_x),
        .s_ready_x  (s_ready_x),
        .s_valid_f  (s_valid_f),
        .s_ready_f  (s_ready_f),
        .x_addr     (x_addr),
        .x_wr_en    (x_wr_en),
        .f_addr     (f_addr),
        .f_wr_en    (f_wr_en),
        .acc_en     (acc_en),
        .acc_first  (acc_first),
        .m_valid_y  (m_valid_y),
        .m_ready_y  (m_ready_y),
        .frame_done (frame_done)
    );

    // Reference datapath: 1-cycle-latency memories and a MAC accumulator.
    assign prod = int'(x_rd) * int'(f_rd);
    always @(posedge clk) begin
        if (x_wr_en) xmem[x_addr] <= x_data;
        if (f_wr_en) fmem[f_addr] <= f_data;
        x_rd <= xmem[x_addr];
        f_rd <= fmem[f_addr];
        if (acc_en) acc <= acc_first ? prod : acc + prod;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_phase(input bit gap);
        int xi = 0, fi = 0, xdone = -1, guard = 0;
        bit vx, vf;
        while ((xi < XS || fi < FS) && guard < 300) begin
            @(negedge clk);
            guard++;
            if (gap) begin
                vx = (xi < XS) && ($urandom_range(0, 2) != 0);
                if (fi < FS - 1) vf = ($urandom_range(0, 3) == 0);
                else vf = (fi < FS) && (xdone >= 0) && (cyc >= xdone + 5);
                if (xi == XS) begin
                    check("rdy_x_low", s_ready_x, 0);
                    if (fi < FS) check("no_compute", acc_en, 0);
                end
            end else begin
                vx = (xi < XS);
                vf = (fi < FS);
            end
            s_valid_x = vx;
            x_data    = vx ? 8'(xv[xi]) : '0;
            s_valid_f = vf;
            f_data    = vf ? 8'(fv[fi]) : '0;
            if (vx && s_ready_x) begin
                xi++;
                last_acc = cyc + 1;
                if (xi == XS) xdone = cyc + 1;
            end
            if (vf && s_ready_f) begin
                fi++;
                last_acc = cyc + 1;
            end
        end
        check("load_timeout", (xi == XS) && (fi == FS), 1);
        @(negedge clk);
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
    endtask

    task automatic out_phase(input int stall_idx, input int trace_base);
        int j = 0, since = 0, tc = 0, fd = 0, guard = 0;
        int snap_x, snap_f;
        bit tracing = 0;
        while (j < YC && guard < 400) begin
            @(negedge clk);
            guard++;
            since++;
            if (frame_done) fd++;
            if (tracing) begin
                tc++;
                if (tc <= FS) begin
                    check("trace_xaddr", x_addr, trace_base + tc - 1);
                    check("trace_faddr", f_addr, tc - 1);
                end
                check("trace_acc_en", acc_en, (tc >= 2 && tc <= FS + 1));
                check("trace_acc_first", acc_first, (tc == 2));
                if (tc == FS + 2) tracing = 0;
            end
            if (m_valid_y) begin
                check($sformatf("y%0d", j), acc, expy[j]);
                if (j == 0) check("lat_first", cyc - last_acc, FS + 2);
                else check("spacing", since, FS + 2);
                if (j == stall_idx) begin
                    m_ready_y = 1'b0;
                    s_valid_x = 1'b1;
                    s_valid_f = 1'b1;
                    snap_x = int'(x_addr);
                    snap_f = int'(f_addr);
                    repeat (10) begin
                        @(negedge clk);
                        check("stall_valid", m_valid_y, 1);
                        check("stall_acc_en", acc_en, 0);
                        check("stall_xaddr", x_addr, snap_x);
                        check("stall_faddr", f_addr, snap_f);
                        check("stall_wr", x_wr_en | f_wr_en, 0);
                        if (frame_done) fd++;
                    end
                    m_ready_y = 1'b1;
                    s_valid_x = 1'b0;
                    s_valid_f = 1'b0;
                    #1;
                end
                check("fdone_at_accept", frame_done, (j == YC - 1));
                j++;
                since = 0;
                if (j == trace_base) begin
                    tracing = 1;
                    tc = 0;
                end
            end
        end
        if (j < YC) check("out_timeout", j, YC);
        check("fdone_count", fd, 1);
        @(negedge clk);
        check("rdy_x_after", s_ready_x, 1);
        check("rdy_f_after", s_ready_f, 1);
    endtask

    task automatic set_frame_a();
        xv   = '{10, -20, 30, -40, 50, 60, 70, 80};
        fv   = '{10, 20, -30, 40};
        expy = '{-2800, 3600, 400, 1600, 2800};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        x_data    = '0;
        f_data    = '0;
        m_ready_y = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_m_valid", m_valid_y, 0);
        check("rst_acc_en", acc_en, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdy_x", s_ready_x, 1);
        check("rst_rdy_f", s_ready_f, 1);
        check("rst_fdone", frame_done, 0);

        set_frame_a();
        load_phase(0);
        out_phase(-1, 2);

        load_phase(1);
        out_phase(-1, -1);

        load_phase(0);
        out_phase(3, -1);

        for (int i = 0; i < XS; i++) xv[i] = i + 1;
        fv   = '{1, 1, 1, 1};
        expy = '{10, 14, 18, 22, 26};
        load_phase(0);
        out_phase(-1, -1);

        set_frame_a();
        load_phase(0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_acc_en", acc_en, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_m_valid", m_valid_y, 0);
        check("arst_acc_en", acc_en, 0);
        check("arst_wr", x_wr_en | f_wr_en, 0);
        check("arst_load", s_ready_x & s_ready_f, 1);
        @(negedge clk);
        reset = 1'b0;
        load_phase(0);
        out_phase(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
